// File: rtl/dcache_controller.sv
// Sequential data-cache controller: single-cycle load hits, write-through stores, burst line refill.
// Define DCACHE_PERF_CNT_EN to add saturating hit_count/miss_count outputs.
module dcache_controller #(
    parameter int WordSize  = 32,
    parameter int AddrSize  = 32,
    parameter int LineWords = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         dcache_en,
    input  logic                         dcache_rw,
    input  logic [AddrSize-1:0]          cpu_addr,
    input  logic [WordSize-1:0]          cpu_wdata,
    input  logic                         cache_hit,
    output logic                         stall,
    output logic                         cpu_ready,
    output logic                         read_enable,
    output logic                         write_enable,
    output logic                         fill_en,
    output logic [$clog2(LineWords)-1:0] fill_word,
    output logic [WordSize-1:0]          fill_data,
    output logic                         mem_req,
    output logic                         mem_wEn,
    output logic [AddrSize-1:0]          mem_addr,
    output logic [WordSize-1:0]          mem_wdata,
    output logic                         isBurst,
    input  logic                         mem_busy,
    input  logic                         mem_rvalid,
    input  logic [WordSize-1:0]          mem_rdata
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]                  hit_count,
    output logic [31:0]                  miss_count
`endif
);
    localparam int CntW = $clog2(LineWords);
    localparam int OffW = $clog2(LineWords * WordSize / 8);

    typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, RD_FILL, RD_DONE} state_t;

    state_t               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [AddrSize-1:0]  addr_q, addr_d;
    logic [WordSize-1:0]  data_q, data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Handshake strobes are combinational so hits and accepts complete in the same cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        data_d       = data_q;
        stall        = 1'b0;
        cpu_ready    = 1'b0;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        fill_en      = 1'b0;
        fill_word    = '0;
        fill_data    = '0;
        mem_req      = 1'b0;
        mem_wEn      = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        isBurst      = 1'b0;
        case (state_q)
            IDLE: begin
                if (dcache_en) begin
                    if (!dcache_rw && cache_hit) begin
                        read_enable = 1'b1;
                        cpu_ready   = 1'b1;
                    end else if (!dcache_rw) begin
                        stall   = 1'b1;
                        addr_d  = cpu_addr;
                        state_d = RD_REQ;
                    end else begin
                        write_enable = cache_hit;
                        stall        = 1'b1;
                        addr_d       = cpu_addr;
                        data_d       = cpu_wdata;
                        state_d      = WR_REQ;
                    end
                end
            end
            WR_REQ: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_wEn   = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = data_q;
                if (!mem_busy) begin
                    cpu_ready = 1'b1;
                    state_d   = IDLE;
                end
            end
            RD_REQ: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                isBurst  = 1'b1;
                mem_addr = {addr_q[AddrSize-1:OffW], {OffW{1'b0}}};
                if (!mem_busy) begin
                    cnt_d   = '0;
                    state_d = RD_FILL;
                end
            end
            RD_FILL: begin
                stall = 1'b1;
                if (mem_rvalid) begin
                    fill_en   = 1'b1;
                    fill_word = cnt_q;
                    fill_data = mem_rdata;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == CntW'(LineWords - 1)) state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                read_enable = 1'b1;
                cpu_ready   = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset forces every output low immediately, even while inputs are active.
        if (rst) begin
            stall        = 1'b0;
            cpu_ready    = 1'b0;
            read_enable  = 1'b0;
            write_enable = 1'b0;
            fill_en      = 1'b0;
            fill_word    = '0;
            fill_data    = '0;
            mem_req      = 1'b0;
            mem_wEn      = 1'b0;
            mem_addr     = '0;
            mem_wdata    = '0;
            isBurst      = 1'b0;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_q, miss_q;
    logic        hitEvt, missEvt;

    assign hitEvt  = (state_q == IDLE) && dcache_en && cache_hit;
    assign missEvt = (state_q == IDLE) && dcache_en && !cache_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (hitEvt && (hit_q != 32'hFFFF_FFFF))   hit_q  <= hit_q + 32'd1;
            if (missEvt && (miss_q != 32'hFFFF_FFFF)) miss_q <= miss_q + 32'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`endif
endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: stimulus pushes expected events, a negedge monitor pops and compares.
// Build with DCACHE_PERF_CNT_EN defined to also check the hit/miss counters.
module tb_dcache_controller;
    localparam int LW = 4;
    localparam int WS = 32;
    localparam int AS = 32;

    localparam int K_WEN  = 0;
    localparam int K_WR   = 1;
    localparam int K_RD   = 2;
    localparam int K_FILL = 3;
    localparam int K_DONE = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          dcache_en, dcache_rw, cache_hit;
    logic [AS-1:0] cpu_addr;
    logic [WS-1:0] cpu_wdata;
    logic          stall, cpu_ready, read_enable, write_enable, fill_en;
    logic [1:0]    fill_word;
    logic [WS-1:0] fill_data;
    logic          mem_req, mem_wEn, isBurst;
    logic [AS-1:0] mem_addr;
    logic [WS-1:0] mem_wdata;
    logic          mem_busy, mem_rvalid;
    logic [WS-1:0] mem_rdata;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]   hit_count, miss_count;
`endif

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        int          idx;
    } ev_t;

    ev_t         expQ[$];
    int          checks = 0;
    int          errors = 0;
    bit          monEn = 1'b0;
    int          modelHits = 0;
    int          modelMisses = 0;
    logic [31:0] memModel [logic [31:0]];

    always #5 clk = ~clk;

    dcache_controller #(.WordSize(WS), .AddrSize(AS), .LineWords(LW)) dut (
        .clk(clk), .rst(rst),
        .dcache_en(dcache_en), .dcache_rw(dcache_rw), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cache_hit(cache_hit),
        .stall(stall), .cpu_ready(cpu_ready), .read_enable(read_enable),
        .write_enable(write_enable), .fill_en(fill_en), .fill_word(fill_word),
        .fill_data(fill_data), .mem_req(mem_req), .mem_wEn(mem_wEn),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .isBurst(isBurst),
        .mem_busy(mem_busy), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef DCACHE_PERF_CNT_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    // Backing memory: written words override a fixed address hash.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (memModel.exists(a)) return memModel[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic ev_t mkEv(input int kind, input logic [31:0] addr,
                                 input logic [31:0] data, input int idx);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        e.idx  = idx;
        return e;
    endfunction

    function automatic logic anyOut();
        return |{stall, cpu_ready, read_enable, write_enable, fill_en, fill_word,
                 fill_data, mem_req, mem_wEn, mem_addr, mem_wdata, isBurst};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: classifies each cycle's observable event and compares it with the queue head.
    always @(negedge clk) begin : monitor
        int  k;
        bit  ok;
        ev_t e;
        if (!rst && monEn) begin
            k = -1;
            if (write_enable)              k = K_WEN;
            else if (fill_en)              k = K_FILL;
            else if (mem_req && !mem_busy) k = mem_wEn ? K_WR : K_RD;
            else if (cpu_ready)            k = K_DONE;
            if (k >= 0) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected event: kind %0d seen, nothing expected", k);
                end else begin
                    e  = expQ.pop_front();
                    ok = (e.kind == k);
                    if (ok) begin
                        case (k)
                            K_WEN:  ok = stall && !cpu_ready && !mem_req;
                            K_WR:   ok = (mem_addr == e.addr) && (mem_wdata == e.data) &&
                                         !isBurst && cpu_ready && stall;
                            K_RD:   ok = (mem_addr == e.addr) && isBurst && !cpu_ready && stall;
                            K_FILL: ok = (int'(fill_word) == e.idx) && (fill_data == e.data) &&
                                         stall && !read_enable;
                            default: ok = read_enable && !stall && !mem_req && !fill_en && !write_enable;
                        endcase
                    end
                    if (!ok) begin
                        errors++;
                        $display("[TB] FAIL scoreboard: got kind=%0d addr=%08h data=%08h word=%0d rdy=%b stall=%b burst=%b, expected kind=%0d addr=%08h data=%08h word=%0d",
                                 k, mem_addr, fill_en ? fill_data : mem_wdata, fill_word,
                                 cpu_ready, stall, isBurst, e.kind, e.addr, e.data, e.idx);
                    end
                end
            end
        end
    end

    // One CPU access, held until completion while the memory side is modelled cycle by cycle.
    task automatic applyStimulus(input bit isStore, input bit hit, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int forceBusy,
                                 input logic [15:0] rvMask);
        logic [31:0] lineBase;
        int          beatsIssued;
        int          fillCyc;
        bit          burstLive;
        bit          done;
        bit          give;
        lineBase = addr & ~32'(LW * WS / 8 - 1);
        if (!isStore) begin
            if (hit) expQ.push_back(mkEv(K_DONE, 0, 0, 0));
            else begin
                expQ.push_back(mkEv(K_RD, lineBase, 0, 0));
                for (int i = 0; i < LW; i++)
                    expQ.push_back(mkEv(K_FILL, 0, memWord(lineBase + 32'(4 * i)), i));
                expQ.push_back(mkEv(K_DONE, 0, 0, 0));
            end
        end else begin
            if (hit) expQ.push_back(mkEv(K_WEN, 0, 0, 0));
            expQ.push_back(mkEv(K_WR, addr, wdata, 0));
            memModel[addr & ~32'd3] = wdata;
        end
        if (hit) modelHits++;
        else     modelMisses++;

        @(posedge clk); #1;
        dcache_en  = 1'b1;
        dcache_rw  = isStore;
        cache_hit  = hit;
        cpu_addr   = addr;
        cpu_wdata  = wdata;
        mem_busy   = 1'b0;
        mem_rvalid = 1'b0;
        beatsIssued = 0;
        fillCyc     = 0;
        burstLive   = 1'b0;
        done        = 1'b0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            if (cpu_ready) done = 1'b1;
            if (mem_req && !mem_busy && isBurst) burstLive = 1'b1;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            if (!done) begin
                mem_busy = (forceBusy >= 0) ? (cyc < forceBusy) : ($urandom_range(0, 2) == 0);
                if (burstLive && beatsIssued < LW) begin
                    if (rvMask != 16'h0 && fillCyc < 16) give = rvMask[fillCyc];
                    else if (rvMask != 16'h0)            give = 1'b1;
                    else                                 give = ($urandom_range(0, 2) != 0);
                    fillCyc++;
                    if (give) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = memWord(lineBase + 32'(4 * beatsIssued));
                        beatsIssued++;
                    end
                end else if ($urandom_range(0, 4) == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = $urandom;
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL access timeout: got no cpu_ready, expected one within 300 cycles (addr %08h)", addr);
        end
        dcache_en  = 1'b0;
        mem_busy   = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int fills;
        rst = 1'b1;
        dcache_en = 1'b0; dcache_rw = 1'b0; cache_hit = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        mem_busy = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset outputs", {31'b0, anyOut()}, 32'd0);
        rst   = 1'b0;
        monEn = 1'b1;

        applyStimulus(1'b0, 1'b1, 32'h0000_0100, 32'h0, 0, 16'h0);
        memModel[32'h1230] = 32'hA0; memModel[32'h1234] = 32'hA1;
        memModel[32'h1238] = 32'hA2; memModel[32'h123C] = 32'hA3;
        applyStimulus(1'b0, 1'b0, 32'h0000_1234, 32'h0, 0, 16'h0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 3, 16'h0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0080, 32'h1357_9BDF, 0, 16'h0);
        applyStimulus(1'b0, 1'b0, 32'h0000_0048, 32'h0, 0, 16'h009A);

        // Stray read beat while idle must not reach the array.
        @(posedge clk); #1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        checkOutput("stray rvalid fill_en", {31'b0, fill_en}, 32'd0);
        checkOutput("stray rvalid stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;

        // Reset in the middle of a refill, after two beats.
        monEn = 1'b0;
        @(posedge clk); #1;
        dcache_en = 1'b1; dcache_rw = 1'b0; cache_hit = 1'b0; cpu_addr = 32'h0000_2468;
        fills = 0;
        for (int c = 0; c < 40 && fills < 2; c++) begin
            @(negedge clk);
            if (fill_en) fills++;
            @(posedge clk); #1;
            mem_rvalid = (fills < 2);
            mem_rdata  = 32'(c);
        end
        mem_rvalid = 1'b0;
        checkOutput("mid-burst beats", 32'(fills), 32'd2);
        checkOutput("mid-burst stall", {31'b0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid-burst reset outputs", {31'b0, anyOut()}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcache_en = 1'b0;
        modelHits = 0;
        modelMisses = 0;
        #1;
        checkOutput("post-reset stall", {31'b0, stall}, 32'd0);
        monEn = 1'b1;

        applyStimulus(1'b0, 1'b0, 32'h0000_2468, 32'h0, -1, 16'h0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0204, 32'h0, -1, 16'h0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, -1, 16'h0);
`ifdef DCACHE_PERF_CNT_EN
        checkOutput("hit_count directed", hit_count, 32'd1);
        checkOutput("miss_count directed", miss_count, 32'd2);
`endif

        for (int n = 0; n < 60; n++)
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, -1, 16'h0);

        repeat (3) @(posedge clk);
`ifdef DCACHE_PERF_CNT_EN
        checkOutput("hit_count final", hit_count, 32'(modelHits));
        checkOutput("miss_count final", miss_count, 32'(modelMisses));
`endif
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
